// File: rtl/mips_pkg.sv
// Shared constants for the instruction-memory loader: word/byte geometry,
// loader state encoding and the byte-lane address helper.
package mips_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

    typedef logic [1:0] ld_state_t;

    localparam ld_state_t ST_IDLE   = 2'd0;
    localparam ld_state_t ST_ACCEPT = 2'd1;
    localparam ld_state_t ST_WRITE  = 2'd2;
    localparam ld_state_t ST_DONE   = 2'd3;

    function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [1:0] idx);
        return base + {30'd0, idx};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bundle: session control, word stream, byte write port and status.
import mips_pkg::*;

interface imem_loader_if;
    logic              load_start;
    logic [WORD_W-1:0] word_in;
    logic              word_last;
    logic              word_valid;
    logic              word_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [BYTE_W-1:0] mem_wdata;
    logic              busy;
    logic              load_done;
    logic              load_full;
    logic [31:0]       word_count;

    modport master (
        output load_start, word_in, word_last, word_valid,
        input  word_ready, mem_we, mem_addr, mem_wdata, busy, load_done, load_full, word_count
    );

    modport slave (
        input  load_start, word_in, word_last, word_valid,
        output word_ready, mem_we, mem_addr, mem_wdata, busy, load_done, load_full, word_count
    );
endinterface

// File: rtl/imem_loader_serializer.sv
// Holds one instruction word and presents it MSB byte first; each shift
// advances to the next byte lane.
module word_serializer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift,
    output logic [BYTE_W-1:0] o_byte,
    output logic [1:0]        o_idx
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_idx;

    // Word shift register and byte index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= 2'd0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= 2'd0;
        end else if (i_shift) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_byte = r_word[WORD_W-1 -: BYTE_W];
    assign o_idx  = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory write-side loader: takes 32-bit words from a valid/ready
// stream and writes them big-endian, one byte per cycle, from BASE_ADDR upward.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 32,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    ld_state_t         r_state;
    ld_state_t         w_state_nxt;
    logic [31:0]       r_addr;
    logic [31:0]       r_count;
    logic              r_last;
    logic              r_full;

    logic              w_accept;
    logic              w_writing;
    logic              w_word_end;
    logic              w_no_room;
    logic [31:0]       w_addr_nxt;
    logic [BYTE_W-1:0] w_byte;
    logic [1:0]        w_idx;

    assign w_accept   = (r_state == ST_ACCEPT) && bus.word_valid;
    assign w_writing  = (r_state == ST_WRITE);
    assign w_word_end = w_writing && (w_idx == 2'd3);
    assign w_addr_nxt = r_addr + 32'(BYTES_PER_WORD);
    // addr is always below DEPTH_BYTES, so the 32-bit sum cannot wrap
    assign w_no_room  = (w_addr_nxt >= 32'(DEPTH_BYTES));

    word_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_word  (bus.word_in),
        .i_shift (w_writing),
        .o_byte  (w_byte),
        .o_idx   (w_idx)
    );

    // Session state sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.load_start) w_state_nxt = ST_ACCEPT;
                else                w_state_nxt = ST_IDLE;
            end
            ST_ACCEPT: begin
                if (bus.word_valid) w_state_nxt = ST_WRITE;
                else                w_state_nxt = ST_ACCEPT;
            end
            ST_WRITE: begin
                if (!w_word_end)             w_state_nxt = ST_WRITE;
                else if (r_last || w_no_room) w_state_nxt = ST_DONE;
                else                         w_state_nxt = ST_ACCEPT;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, address, word counter, last flag and sticky full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'(BASE_ADDR);
            r_count <= 32'd0;
            r_last  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && bus.load_start) begin
                r_addr  <= 32'(BASE_ADDR);
                r_count <= 32'd0;
                r_full  <= 1'b0;
            end
            if (w_accept) begin
                r_last <= bus.word_last;
            end
            if (w_word_end) begin
                r_addr  <= w_addr_nxt;
                r_count <= r_count + 32'd1;
                // a final word that exactly fills memory is not a "full" stop
                if (!r_last && w_no_room) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign bus.word_ready = (r_state == ST_ACCEPT);
    assign bus.mem_we     = w_writing;
    assign bus.mem_addr   = w_writing ? byte_addr(r_addr, w_idx) : 32'd0;
    assign bus.mem_wdata  = w_writing ? w_byte : {BYTE_W{1'b0}};
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.load_done  = (r_state == ST_DONE);
    assign bus.load_full  = r_full;
    assign bus.word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a byte-image reference
// model of the instruction memory and per-session expectations.
module tb_imem_loader;
    import mips_pkg::*;

    localparam int DEPTH = 32;
    localparam int BASE  = 0;
    localparam int CAP   = (DEPTH - BASE) / 4;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_clear = 1'b1;

    imem_loader_if bus();

    imem_loader #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;

    logic [7:0] exp_mem [DEPTH];
    logic [7:0] tb_mem  [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // instruction memory: commits a byte on the clock edge
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'h00;
        end else if (bus.mem_we && (bus.mem_addr < 32'(DEPTH))) begin
            tb_mem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
        end
    end

    // cycle monitor for write data, address range and handshake exclusivity
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.load_done) done_seen++;
            if (bus.mem_we) begin
                check_eq("addr_range", 32'(bus.mem_addr < 32'(DEPTH)), 32'd1);
                check_eq("wdata", 32'(bus.mem_wdata), 32'(exp_mem[bus.mem_addr[AW-1:0]]));
                check_eq("ready_in_write", 32'(bus.word_ready), 32'd0);
            end
            if (bus.word_ready) check_eq("ready_busy", 32'(bus.busy), 32'd1);
        end
    end

    task automatic mem_image_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== exp_mem[i]) bad++;
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    task automatic start_session();
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    // offer one word; on handshake update the model image and check first-byte latency
    task automatic send_word(input logic [31:0] w, input logic last, input int gap,
                             input int widx, input bit poke, output bit accepted);
        logic [AW-1:0] ai;
        int a;
        repeat (gap) @(negedge clk);
        bus.word_in    = w;
        bus.word_last  = last;
        bus.word_valid = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 40 && !accepted; t++) begin
            if (bus.word_ready) accepted = 1'b1;
            else                @(negedge clk);
        end
        if (accepted) begin
            @(posedge clk);
            a = BASE + 4 * widx;
            for (int k = 0; k < 4; k++) begin
                ai = AW'(a + k);
                exp_mem[ai] = w[31 - 8*k -: 8];
            end
            @(negedge clk);
            bus.word_valid = 1'b0;
            check_eq("we_latency", 32'(bus.mem_we), 32'd1);
            check_eq("first_addr", bus.mem_addr, 32'(a));
            if (poke) begin
                bus.load_start = 1'b1;
                @(negedge clk);
                bus.load_start = 1'b0;
            end
        end else begin
            bus.word_valid = 1'b0;
        end
    endtask

    task automatic run_session(input int n, input int last_idx, input int gmin, input int gmax,
                               input bit poke);
        int  exp_words;
        bit  exp_full;
        bit  acc;
        int  done0;
        logic [31:0] w;
        exp_full  = !(last_idx >= 0 && last_idx < CAP);
        exp_words = exp_full ? CAP : last_idx + 1;
        done0 = done_seen;
        start_session();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (i < exp_words) begin
                send_word(w, i == last_idx, $urandom_range(gmax, gmin), i, poke && (i == 0), acc);
                check_eq("accepted", 32'(acc), 32'd1);
            end else begin
                send_word(w, i == last_idx, 0, i, 1'b0, acc);
                check_eq("extra_refused", 32'(acc), 32'd0);
                break;
            end
        end
        for (int t = 0; t < 60 && bus.busy; t++) begin
            if (bus.load_done && poke) begin
                bus.load_start = 1'b1;
                @(negedge clk);
                bus.load_start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("session_end", 32'(bus.busy), 32'd0);
        check_eq("done_pulses", 32'(done_seen - done0), 32'd1);
        check_eq("word_count", bus.word_count, 32'(exp_words));
        check_eq("load_full", 32'(bus.load_full), 32'(exp_full));
        repeat (3) @(negedge clk);
        check_eq("idle_hold", 32'(bus.busy), 32'd0);
        check_eq("count_hold", bus.word_count, 32'(exp_words));
        mem_image_check("mem_image");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        int li;
        bus.load_start = 1'b0;
        bus.word_in    = 32'd0;
        bus.word_last  = 1'b0;
        bus.word_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;

        // power-on reset values
        #13;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ready", 32'(bus.word_ready), 32'd0);
        check_eq("rst_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_addr", bus.mem_addr, 32'd0);
        check_eq("rst_count", bus.word_count, 32'd0);
        check_eq("rst_full", 32'(bus.load_full), 32'd0);
        check_eq("rst_done", 32'(bus.load_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tb_clear = 1'b0;

        // single last word, byte order and done timing
        start_session();
        send_word(32'h8C010004, 1'b1, 0, 0, 1'b0, acc);
        check_eq("t2_accepted", 32'(acc), 32'd1);
        check_eq("t2_byte0", 32'(bus.mem_wdata), 32'h8C);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check_eq("t2_we", 32'(bus.mem_we), 32'd1);
            check_eq("t2_addr", bus.mem_addr, 32'(k));
        end
        @(negedge clk);
        check_eq("t2_done", 32'(bus.load_done), 32'd1);
        @(negedge clk);
        check_eq("t2_done_drop", 32'(bus.load_done), 32'd0);
        check_eq("t2_busy", 32'(bus.busy), 32'd0);
        check_eq("t2_count", bus.word_count, 32'd1);
        check_eq("t2_full", 32'(bus.load_full), 32'd0);
        mem_image_check("t2_image");

        // reset in the middle of a word: first two bytes stay, the rest do not
        start_session();
        send_word(32'hA1B2C3D4, 1'b1, 0, 0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        check_eq("t1_idx2", bus.mem_addr, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t1_we", 32'(bus.mem_we), 32'd0);
        check_eq("t1_busy", 32'(bus.busy), 32'd0);
        check_eq("t1_addr", bus.mem_addr, 32'd0);
        check_eq("t1_wdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("t1_count", bus.word_count, 32'd0);
        exp_mem[2] = 8'h00;
        exp_mem[3] = 8'h04;
        @(negedge clk);
        rst = 1'b0;
        mem_image_check("t1_image");

        // three gapped words, last on the third
        run_session(3, 2, 2, 2, 1'b0);
        // overflow: nine words without last
        run_session(9, -1, 0, 1, 1'b0);
        // exact fill with last on the eighth word
        run_session(8, 7, 0, 1, 1'b0);
        // load_start pokes in WRITE and DONE, then a fresh session from base
        run_session(2, 1, 0, 1, 1'b1);
        run_session(1, 0, 0, 0, 1'b0);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(3, 0) == 0) begin
                n  = CAP + 1;
                li = -1;
            end else begin
                n  = $urandom_range(CAP + 1, 1);
                li = $urandom_range(n - 1, 0);
            end
            run_session(n, li, 0, 3, 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
